mcl_fxd_pipe_mac_stage: RTL

Parametrised successor to the Horner basic block: one fused fixed-point multiply-add stage, post = mult_1*mult_2 + add_1, followed by a configurable-depth elastic pipeline.
Side-band operands (x, x^2, ...) travel in the same token as the result, so they stay cycle-aligned with it; separate side pipelines are no longer needed.
Adds selectable rounding, saturation with overflow flag, and an occupancy counter. Chains PIPE_DEPTH-deep Horner stages in the sine evaluator.

---
 rtl/mcl_fxd_pkg.sv | 62 ++++++
 rtl/mcl_fxd_elastic_stage.sv | 39 +++
 rtl/mcl_fxd_pipe_mac_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mcl_fxd_pkg.sv
// Fixed-point helpers shared by the multiply-add pipeline.
//   FXD_MAX(n) / FXD_MIN(n) : largest / smallest n-bit two's-complement code,
//                             sign-extended to fxd_word_t.
//   fxd_mul_add(a,b,c,n,q,round,sat) : returns {ovf, result}.
//     result = (a*b [+ 2^(q-1) when round]) >>> q, plus c.
//     If the sum does not fit n signed bits, ovf=1 and the result is either
//     clamped to FXD_MAX/FXD_MIN (sat=1) or the low n bits of the sum (sat=0).
// Operands are passed sign-extended to FXD_WMAX bits so that one function
// serves every word width up to FXD_WMAX. The working width of
// 2*FXD_WMAX+1 bits cannot overflow for any n <= FXD_WMAX.
package mcl_fxd_pkg;

  localparam int FXD_WMAX = 32;

  typedef logic signed [FXD_WMAX-1:0] fxd_word_t;
  typedef logic signed [2*FXD_WMAX:0] fxd_wide_t;

  function automatic fxd_word_t FXD_MAX(input int n);
    fxd_wide_t one;
    one = fxd_wide_t'(1);
    return fxd_word_t'((one <<< (n - 1)) - one);
  endfunction

  function automatic fxd_word_t FXD_MIN(input int n);
    fxd_wide_t one;
    one = fxd_wide_t'(1);
    return fxd_word_t'(-(one <<< (n - 1)));
  endfunction

  function automatic logic [FXD_WMAX:0] fxd_mul_add(
    input fxd_word_t a,
    input fxd_word_t b,
    input fxd_word_t c,
    input int        n,
    input int        q,
    input logic      round,
    input logic      sat
  );
    fxd_wide_t acc;
    fxd_wide_t hi;
    fxd_wide_t lo;
    fxd_word_t res;
    logic      ovf;
    acc = fxd_wide_t'(a) * fxd_wide_t'(b);
    if (round) begin
      acc = acc + (fxd_wide_t'(1) <<< (q - 1));
    end
    // Arithmetic shift gives floor division, so truncation rounds toward -inf.
    acc = acc >>> q;
    acc = acc + fxd_wide_t'(c);
    hi  = fxd_wide_t'(FXD_MAX(n));
    lo  = fxd_wide_t'(FXD_MIN(n));
    ovf = (acc > hi) || (acc < lo);
    if (ovf && sat) begin
      res = (acc > hi) ? FXD_MAX(n) : FXD_MIN(n);
    end else begin
      res = acc[FXD_WMAX-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/mcl_fxd_elastic_stage.sv
// One elastic pipeline register: a valid bit plus a W-bit payload.
//   in_valid / in_data / in_ready    : upstream side (in_ready is this stage's ready)
//   out_valid / out_data / out_ready : downstream side (out_ready is next stage's ready)
// The stage loads whenever it is empty or its content is leaving this cycle,
// which lets bubbles collapse and sustains one token per cycle. While full and
// blocked the payload is held unchanged.
module mcl_fxd_elastic_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/mcl_fxd_pipe_mac_stage.sv
// Fused fixed-point multiply-add (mult_1*mult_2 + add_1) followed by a
// PIPE_DEPTH-deep elastic pipeline.
//   pre_*_mult_1 / pre_*_mult_2 / pre_*_add_1 : operand streams (avail/get/data)
//   pre_*_side     : side-band words carried unchanged alongside the result
//   post_avail / post_get : output handshake
//   post_data      : multiply-add result (FXD_N bits, Q-format FXD_Q)
//   post_data_side : side-band words of the same token
//   post_ovf       : the result of this token overflowed
//   occupancy      : number of tokens held in the pipeline
// All four input streams are joined: they transfer together or not at all.
// Each token is packed as {ovf, side, result} so the side band can never
// drift out of alignment with its result.
module mcl_fxd_pipe_mac_stage
  import mcl_fxd_pkg::*;
#(
  parameter int FXD_Q      = 4,
  parameter int FXD_N      = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int NUM_SIDE   = 2,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          pre_avail_mult_1,
  output logic                                          pre_get_mult_1,
  input  logic [FXD_N-1:0]                              pre_data_mult_1,
  input  logic                                          pre_avail_mult_2,
  output logic                                          pre_get_mult_2,
  input  logic [FXD_N-1:0]                              pre_data_mult_2,
  input  logic                                          pre_avail_add_1,
  output logic                                          pre_get_add_1,
  input  logic [FXD_N-1:0]                              pre_data_add_1,
  input  logic                                          pre_avail_side,
  output logic                                          pre_get_side,
  input  logic [((NUM_SIDE > 0) ? NUM_SIDE*FXD_N : 1)-1:0] pre_data_side,
  output logic                                          post_avail,
  input  logic                                          post_get,
  output logic [FXD_N-1:0]                              post_data,
  output logic [((NUM_SIDE > 0) ? NUM_SIDE*FXD_N : 1)-1:0] post_data_side,
  output logic                                          post_ovf,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]               occupancy
);

  localparam int SIDE_W = (NUM_SIDE > 0) ? NUM_SIDE * FXD_N : 1;
  localparam int TOK_W  = 1 + SIDE_W + FXD_N;
  localparam int OCC_W  = $clog2(PIPE_DEPTH + 1);

  // Multiply-add on the operands currently offered.
  logic [FXD_N-1:0]  mac_result;
  logic              mac_ovf;
  logic [SIDE_W-1:0] in_side;

  assign mac_result = FXD_N'(fxd_mul_add(
                        fxd_word_t'($signed(pre_data_mult_1)),
                        fxd_word_t'($signed(pre_data_mult_2)),
                        fxd_word_t'($signed(pre_data_add_1)),
                        FXD_N, FXD_Q, (ROUND_MODE != 0), (SATURATE != 0)));
  assign mac_ovf    = 1'(fxd_mul_add(
                        fxd_word_t'($signed(pre_data_mult_1)),
                        fxd_word_t'($signed(pre_data_mult_2)),
                        fxd_word_t'($signed(pre_data_add_1)),
                        FXD_N, FXD_Q, (ROUND_MODE != 0), (SATURATE != 0))
                        >> FXD_WMAX);

  // Pipeline chains: index 0 is the input join, index PIPE_DEPTH the output.
  logic [PIPE_DEPTH:0] valid_chain;
  logic [PIPE_DEPTH:0] ready_chain;
  logic [TOK_W-1:0]    tok_chain [PIPE_DEPTH+1];

  logic take_in;
  logic take_out;

  assign take_in  = pre_avail_mult_1 & pre_avail_mult_2 & pre_avail_add_1
                  & pre_avail_side & ready_chain[0];
  assign take_out = valid_chain[PIPE_DEPTH] & post_get;

  assign pre_get_mult_1 = take_in;
  assign pre_get_mult_2 = take_in;
  assign pre_get_add_1  = take_in;
  assign pre_get_side   = take_in;

  assign valid_chain[0]          = take_in;
  assign tok_chain[0]            = {mac_ovf, in_side, mac_result};
  assign ready_chain[PIPE_DEPTH] = post_get;

  generate
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      mcl_fxd_elastic_stage #(
        .W (TOK_W)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (valid_chain[gi]),
        .in_data   (tok_chain[gi]),
        .in_ready  (ready_chain[gi]),
        .out_valid (valid_chain[gi+1]),
        .out_data  (tok_chain[gi+1]),
        .out_ready (ready_chain[gi+1])
      );
    end
  endgenerate

  logic [TOK_W-1:0] out_tok;
  assign out_tok    = tok_chain[PIPE_DEPTH];
  assign post_avail = valid_chain[PIPE_DEPTH];
  assign post_data  = out_tok[FXD_N-1:0];
  assign post_ovf   = out_tok[TOK_W-1];

  generate
    if (NUM_SIDE > 0) begin : g_side
      assign in_side        = pre_data_side;
      assign post_data_side = out_tok[FXD_N +: SIDE_W];
    end else begin : g_no_side
      assign in_side        = 1'b0;
      assign post_data_side = 1'b0;
    end
  endgenerate

  // Occupancy tracks tokens in flight; simultaneous in and out cancel.
  logic [OCC_W-1:0] occ_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else if (take_in && !take_out) begin
      occ_reg <= occ_reg + OCC_W'(1);
    end else if (!take_in && take_out) begin
      occ_reg <= occ_reg - OCC_W'(1);
    end
  end

  assign occupancy = occ_reg;

endmodule
